// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression engine: state encoding,
// sizes, initial hash value and the round-constant table used by the datapath.
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } sha256_ctrl_state_t;

  localparam logic [WORD_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: cleared outside the round phase, wraps at the last round so
// the index can never reach NUM_ROUNDS.
module sha256_round_counter #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          enable,
  output logic                          tc,
  output logic [$clog2(NUM_ROUNDS)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);

  assign tc = (idx == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx <= '0;
    end else if (enable) begin
      idx <= tc ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 compression engine: block handshake, schedule and
// round strobes, hash chaining across blocks and the digest handshake.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int BLOCK_W    = 512
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          blk_valid,
  output logic                          blk_ready,
  input  logic [BLOCK_W-1:0]            blk_data,
  input  logic                          blk_first,
  input  logic                          blk_last,
  output logic [BLOCK_W-1:0]            w_block,
  output logic                          w_init,
  output logic                          w_next,
  output logic                          wv_load,
  output logic                          h_load_iv,
  output logic                          round_en,
  output logic [$clog2(NUM_ROUNDS)-1:0] round_idx,
  output logic                          h_update,
  output logic                          digest_valid,
  input  logic                          digest_ready,
  output logic                          busy
);

  import sha256_pkg::*;

  localparam int IDX_W = $clog2(NUM_ROUNDS);

  sha256_ctrl_state_t state, state_nxt;
  logic [IDX_W-1:0]   t;
  logic               t_last;
  logic               chain_open;
  logic               first_q;
  logic               last_q;
  logic               accept;

  assign accept = blk_valid && (state == ST_IDLE);

  sha256_round_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_round_counter (
    .clk    (clk),
    .rst_n  (Reset),
    .clear  (state != ST_ROUND),
    .enable (state == ST_ROUND),
    .tc     (t_last),
    .idx    (t)
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (blk_valid) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_ROUND;
      ST_ROUND:  if (t_last) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:   if (digest_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    blk_ready    = 1'b0;
    w_init       = 1'b0;
    w_next       = 1'b0;
    wv_load      = 1'b0;
    h_load_iv    = 1'b0;
    round_en     = 1'b0;
    round_idx    = '0;
    h_update     = 1'b0;
    digest_valid = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_IDLE:   blk_ready = 1'b1;
      ST_LOAD: begin
        w_init    = 1'b1;
        wv_load   = 1'b1;
        h_load_iv = first_q;
      end
      ST_ROUND: begin
        round_en  = 1'b1;
        round_idx = t;
        // The last round consumes W[63] already in place, so no shift is needed.
        w_next    = !t_last;
      end
      ST_UPDATE: h_update = 1'b1;
      ST_DONE:   digest_valid = 1'b1;
      default: ;
    endcase
  end

  // A block without blk_first still restarts from IV when no chain is open.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      chain_open <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      w_block    <= '0;
    end else begin
      if (accept) begin
        w_block <= blk_data;
        first_q <= blk_first || !chain_open;
        last_q  <= blk_last;
      end
      if (state == ST_UPDATE) begin
        chain_open <= !last_q;
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a phase-based controller model checked every cycle,
// plus a SHA-256 datapath model driven by the DUT strobes to check real digests.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic [511:0] w_block;
  logic         w_init, w_next, wv_load, h_load_iv, round_en, h_update;
  logic [5:0]   round_idx;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic         busy;

  sha256_round_ctrl dut (
    .clk(clk), .Reset(Reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .w_block(w_block), .w_init(w_init), .w_next(w_next), .wv_load(wv_load),
    .h_load_iv(h_load_iv), .round_en(round_en), .round_idx(round_idx),
    .h_update(h_update), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Datapath model state
  logic [31:0] H [8];
  logic [31:0] V [8];
  logic [31:0] W [16];

  function automatic logic [255:0] digest();
    return {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]};
  endfunction

  // Controller model: mode 0 idle, 1 block in flight (phase 0 load, 1..64 rounds, 65 update), 2 done
  int           m_mode = 0;
  int           m_ph = 0;
  bit           m_ok = 0;
  bit           m_open = 0, m_first = 0, m_last = 0;
  logic [511:0] m_wblk = '0;

  int cyc = 0;
  int acc_cyc, winit_cyc, hupd_cyc, dv_cyc;
  int n_winit, n_wnext, n_round, n_hupd, n_hiv, n_dv;
  bit dv_seen;

  task automatic clear_counts();
    acc_cyc = -1; winit_cyc = -1; hupd_cyc = -1; dv_cyc = -1;
    n_winit = 0; n_wnext = 0; n_round = 0; n_hupd = 0; n_hiv = 0; n_dv = 0;
    dv_seen = 0;
  endtask

  always @(negedge clk) begin : monitor
    logic [8:0]  exp_ctrl;
    logic [5:0]  exp_idx;
    logic [31:0] t1, t2, nw;
    cyc++;
    if (m_ok) begin
      exp_ctrl = '0;
      exp_idx  = '0;
      if (m_mode == 0) exp_ctrl[8] = 1'b1;
      if (m_mode == 1) begin
        exp_ctrl[7] = (m_ph == 0);
        exp_ctrl[6] = (m_ph >= 1 && m_ph <= 63);
        exp_ctrl[5] = (m_ph == 0);
        exp_ctrl[4] = (m_ph == 0) && m_first;
        exp_ctrl[3] = (m_ph >= 1 && m_ph <= 64);
        exp_ctrl[2] = (m_ph == 65);
        if (m_ph >= 1 && m_ph <= 64) exp_idx = 6'(m_ph - 1);
      end
      exp_ctrl[1] = (m_mode == 2);
      exp_ctrl[0] = (m_mode != 0);
      check("ctrl_outputs", {blk_ready, w_init, w_next, wv_load, h_load_iv, round_en, h_update, digest_valid, busy}, exp_ctrl);
      check("round_idx", round_idx, exp_idx);
      check("w_block", w_block, m_wblk);

      if (blk_valid && blk_ready) acc_cyc = cyc;
      if (w_init) begin n_winit++; if (winit_cyc < 0) winit_cyc = cyc; end
      if (w_next) n_wnext++;
      if (round_en) n_round++;
      if (h_update) begin n_hupd++; hupd_cyc = cyc; end
      if (h_load_iv) n_hiv++;
      if (digest_valid) begin n_dv++; if (dv_cyc < 0) dv_cyc = cyc; end
      if (digest_valid && digest_ready) dv_seen = 1;

      if (h_load_iv) for (int i = 0; i < 8; i++) H[i] = IV[i];
      if (wv_load) for (int i = 0; i < 8; i++) V[i] = h_load_iv ? IV[i] : H[i];
      if (w_init) for (int i = 0; i < 16; i++) W[i] = w_block[32*i +: 32];
      if (round_en) begin
        t1 = V[7] + (rotr(V[4], 6) ^ rotr(V[4], 11) ^ rotr(V[4], 25))
             + ((V[4] & V[5]) ^ (~V[4] & V[6])) + K[round_idx] + W[0];
        t2 = (rotr(V[0], 2) ^ rotr(V[0], 13) ^ rotr(V[0], 22))
             + ((V[0] & V[1]) ^ (V[0] & V[2]) ^ (V[1] & V[2]));
        for (int i = 7; i > 0; i--) V[i] = V[i-1];
        V[4] = V[4] + t1;
        V[0] = t1 + t2;
      end
      if (w_next) begin
        nw = (rotr(W[14], 17) ^ rotr(W[14], 19) ^ (W[14] >> 10)) + W[9]
             + (rotr(W[1], 7) ^ rotr(W[1], 18) ^ (W[1] >> 3)) + W[0];
        for (int i = 0; i < 15; i++) W[i] = W[i+1];
        W[15] = nw;
      end
      if (h_update) for (int i = 0; i < 8; i++) H[i] = H[i] + V[i];
    end

    // Advance the model to what the coming posedge will produce
    if (!Reset) begin
      m_ok = 1; m_mode = 0; m_ph = 0; m_open = 0; m_first = 0; m_last = 0; m_wblk = '0;
    end else if (m_ok) begin
      case (m_mode)
        0: if (blk_valid) begin
             m_wblk = blk_data; m_first = blk_first || !m_open; m_last = blk_last;
             m_mode = 1; m_ph = 0;
           end
        1: if (m_ph == 65) begin
             m_open = !m_last;
             m_mode = m_last ? 2 : 0;
           end else m_ph++;
        default: if (digest_ready) m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [511:0] data, logic first, logic last);
    bit rdy;
    bit ok = 0;
    blk_data = data; blk_first = first; blk_last = last; blk_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      rdy = blk_ready;
      tick();
      ok = rdy;
    end
    blk_valid = 1'b0;
    check("send_accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_digest();
    for (int i = 0; i < 400 && !dv_seen; i++) tick();
    check("digest_timeout", dv_seen, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick();
    check("idle_timeout", busy, 1'b0);
  endtask

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic [511:0] blk_abc, blk_m1, blk_m2, blk_a, blk_b;
  string        msg;
  int           acc1;

  initial begin
    clear_counts();
    blk_abc = '0;
    blk_abc[31:0]    = 32'h61626380;
    blk_abc[511:480] = 32'h00000018;
    msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk_m1 = '0;
    for (int i = 0; i < 14; i++)
      blk_m1[32*i +: 32] = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
    blk_m1[14*32 +: 32] = 32'h80000000;
    blk_m2 = '0;
    blk_m2[511:480] = 32'h000001c0;

    // Reset held three cycles
    Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    check("rst_blk_ready", blk_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {w_init, w_next, wv_load, h_load_iv, round_en, h_update, digest_valid}, 7'b0);
    check("rst_w_block", w_block, 512'b0);

    // Single block "abc"
    clear_counts();
    digest_ready = 1'b1;
    send(blk_abc, 1'b1, 1'b1);
    wait_digest();
    check("abc_winit_lat", winit_cyc - acc_cyc, 1);
    check("abc_wnext_cnt", n_wnext, 63);
    check("abc_round_cnt", n_round, 64);
    check("abc_hupd_lat", hupd_cyc - acc_cyc, 66);
    check("abc_dv_lat", dv_cyc - acc_cyc, 67);
    check("abc_digest", digest(), ABC_DIGEST);
    tick();

    // Two-block message
    clear_counts();
    send(blk_m1, 1'b1, 1'b0);
    acc1 = acc_cyc;
    send(blk_m2, 1'b0, 1'b1);
    check("two_no_dv_between", n_dv, 0);
    check("two_second_accept", acc_cyc - acc1, 67);
    wait_digest();
    check("two_hiv_cnt", n_hiv, 1);
    check("two_digest", digest(), TWO_DIGEST);
    tick();

    // blk_valid held with changing data while busy
    blk_a = {16{32'hc0ffee11}};
    send(blk_a, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      blk_valid = 1'b1;
      for (int j = 0; j < 16; j++) blk_data[32*j +: 32] = $urandom;
      tick();
      if (i % 10 == 9) begin
        check("busy_blk_ready", blk_ready, 1'b0);
        check("busy_w_block_held", w_block, blk_a);
      end
    end
    blk_valid = 1'b0;
    wait_idle();

    // Digest held while consumer stalls
    digest_ready = 1'b0;
    blk_b = {16{32'h12345678}};
    clear_counts();
    send(blk_b, 1'b0, 1'b1);
    for (int i = 0; i < 200 && !digest_valid; i++) tick();
    check("stall_dv_reached", digest_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) begin
        check("stall_dv_held", digest_valid, 1'b1);
        check("stall_blk_ready", blk_ready, 1'b0);
      end
    end
    digest_ready = 1'b1;
    tick();
    check("stall_release_idle", busy, 1'b0);
    check("stall_release_ready", blk_ready, 1'b1);

    // Reset mid-round, then a non-first block after reset
    clear_counts();
    blk_data = blk_b; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 100 && round_idx != 6'd30; i++) tick();
    check("mid_round_reached", round_idx, 6'd30);
    Reset = 1'b0;
    tick();
    check("mid_rst_idle", busy, 1'b0);
    check("mid_rst_idx", round_idx, 6'd0);
    tick();
    Reset = 1'b1;
    tick();
    check("mid_rst_no_hupd", n_hupd, 0);
    clear_counts();
    send(blk_abc, 1'b0, 1'b1);
    wait_digest();
    check("post_rst_forced_first", n_hiv, 1);
    check("post_rst_digest", digest(), ABC_DIGEST);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
